// File: rtl/video_timing_pkg.sv
// Shared 720p60 raster constants, FSM state type and flag payload for the video timing generator.
package video_timing_pkg;

    localparam int unsigned H_ACTIVE_720    = 1280;
    localparam int unsigned H_FP_720        = 110;
    localparam int unsigned H_SYNC_720      = 40;
    localparam int unsigned H_BP_720        = 220;
    localparam int unsigned V_ACTIVE_720    = 720;
    localparam int unsigned V_FP_720        = 5;
    localparam int unsigned V_SYNC_720      = 5;
    localparam int unsigned V_BP_720        = 20;
    localparam int unsigned LOCK_SETTLE_720 = 1024;
    localparam int unsigned CW_720          = 12;

    localparam int unsigned H_TOTAL_720 = H_ACTIVE_720 + H_FP_720 + H_SYNC_720 + H_BP_720;
    localparam int unsigned V_TOTAL_720 = V_ACTIVE_720 + V_FP_720 + V_SYNC_720 + V_BP_720;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    // Single-bit raster outputs carried through the output register stage.
    typedef struct packed {
        logic running;
        logic frame_start;
        logic line_start;
        logic de;
        logic vs;
        logic hs;
    } vt_flags_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lock_qualifier.sv
// Synchronises PLL lock, waits for it to stay high for LOCK_SETTLE clocks, then enables the raster.
module lock_qualifier
    import video_timing_pkg::*;
#(
    parameter int unsigned LOCK_SETTLE = LOCK_SETTLE_720
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_async_i,
    output logic run_en_o,
    output logic run_start_o
);

    localparam int unsigned  SW          = cnt_width(LOCK_SETTLE);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);

    logic [1:0]    sync_q;
    logic          lock_s;
    state_e        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          run_en_q, run_start_q;

    assign lock_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], lock_async_i};
        end
    end

    // Settle count saturates at its terminal value; any low lock sample restarts it.
    always_comb begin
        cnt_d = '0;
        if (lock_s) begin
            cnt_d = (cnt_q == SETTLE_LAST) ? cnt_q : cnt_q + SW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: begin
                if (lock_s) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!lock_s)                   state_d = ST_WAIT;
                else if (cnt_q == SETTLE_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            cnt_q       <= '0;
            run_en_q    <= 1'b0;
            run_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_en_q    <= (state_d == ST_RUN);
            run_start_q <= (state_d == ST_RUN) && (state_q != ST_RUN);
        end
    end

    assign run_en_o    = run_en_q;
    assign run_start_o = run_start_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: lock qualification, h/v counters and a registered decode of sync/DE/coords.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_720,
    parameter int unsigned H_FP        = H_FP_720,
    parameter int unsigned H_SYNC      = H_SYNC_720,
    parameter int unsigned H_BP        = H_BP_720,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_720,
    parameter int unsigned V_FP        = V_FP_720,
    parameter int unsigned V_SYNC      = V_SYNC_720,
    parameter int unsigned V_BP        = V_BP_720,
    parameter logic        HS_POL      = 1'b1,
    parameter logic        VS_POL      = 1'b1,
    parameter int unsigned LOCK_SETTLE = LOCK_SETTLE_720,
    parameter int unsigned CW          = CW_720
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pll_lock,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          running
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    localparam vt_flags_t FLAGS_IDLE = '{
        running:     1'b0,
        frame_start: 1'b0,
        line_start:  1'b0,
        de:          1'b0,
        vs:          ~VS_POL,
        hs:          ~HS_POL
    };

    logic          run_en, run_start;
    logic [CW-1:0] h_q, h_d, v_q, v_d, h_cur, v_cur;
    vt_flags_t     flags_q, flags_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          h_act, v_act, h_sync, v_sync;

    lock_qualifier #(
        .LOCK_SETTLE(LOCK_SETTLE)
    ) u_lock_qualifier (
        .clk         (clk),
        .rst         (rst),
        .lock_async_i(pll_lock),
        .run_en_o    (run_en),
        .run_start_o (run_start)
    );

    // The first RUN cycle is the frame origin, so a re-entry never resumes a partial frame.
    always_comb begin
        h_cur = run_start ? '0 : h_q;
        v_cur = run_start ? '0 : v_q;
        h_d   = '0;
        v_d   = '0;
        if (run_en) begin
            if (h_cur == CW'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_cur == CW'(V_TOTAL - 1)) ? '0 : v_cur + CW'(1);
            end else begin
                h_d = h_cur + CW'(1);
                v_d = v_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // vs decodes only v, which moves solely on the h wrap, so it changes at the h=0 edge.
    always_comb begin
        h_act   = (h_cur < CW'(H_ACTIVE));
        v_act   = (v_cur < CW'(V_ACTIVE));
        h_sync  = (h_cur >= CW'(HS_BEG)) && (h_cur < CW'(HS_END));
        v_sync  = (v_cur >= CW'(VS_BEG)) && (v_cur < CW'(VS_END));
        flags_d = FLAGS_IDLE;
        x_d     = '0;
        y_d     = '0;
        if (run_en) begin
            flags_d.running     = 1'b1;
            flags_d.de          = h_act && v_act;
            flags_d.hs          = h_sync ? HS_POL : ~HS_POL;
            flags_d.vs          = v_sync ? VS_POL : ~VS_POL;
            flags_d.line_start  = (h_cur == '0);
            flags_d.frame_start = (h_cur == '0) && (v_cur == '0);
            if (h_act && v_act) begin
                x_d = h_cur;
                y_d = v_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= FLAGS_IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            flags_q <= flags_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign hs          = flags_q.hs;
    assign vs          = flags_q.vs;
    assign de          = flags_q.de;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = flags_q.line_start;
    assign frame_start = flags_q.frame_start;
    assign running     = flags_q.running;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small-raster instance against a frame-position model, plus a 720p instance.
module tb_video_timing_gen;

    localparam int HA = 8, HFP = 2, HSW = 3, HBP = 2;
    localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
    localparam int LS = 4;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst, pll_lock, pll_lock_hd;
    logic hs, vs, de, line_start, frame_start, running;
    logic [11:0] x, y;
    logic hs_hd, vs_hd, de_hd, ls_hd, fs_hd, run_hd;
    logic [11:0] x_hd, y_hd;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_SETTLE(LS), .CW(12)
    ) u_dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock),
        .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start), .running(running)
    );

    video_timing_gen u_dut_hd (
        .clk(clk), .rst(rst), .pll_lock(pll_lock_hd),
        .hs(hs_hd), .vs(vs_hd), .de(de_hd), .x(x_hd), .y(y_hd),
        .line_start(ls_hd), .frame_start(fs_hd), .running(run_hd)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: RUN holds once lock_s has been high LS consecutive cycles; position counts within the frame.
    bit m_s1, m_s2, m_run, chk_en;
    int m_streak, m_pos;
    int e_hs, e_vs, e_de, e_x, e_y, e_ls, e_fs, e_run;

    always @(posedge clk) begin
        int h, v;
        if (rst) begin
            e_hs = 0; e_vs = 0; e_de = 0; e_x = 0; e_y = 0; e_ls = 0; e_fs = 0; e_run = 0;
            m_s1 = 1'b0; m_s2 = 1'b0; m_streak = 0; m_run = 1'b0; m_pos = 0;
        end else begin
            h     = m_pos % HT;
            v     = m_pos / HT;
            e_run = m_run ? 1 : 0;
            e_de  = (m_run && h < HA && v < VA) ? 1 : 0;
            e_hs  = (m_run && h >= HA + HFP && h < HA + HFP + HSW) ? 1 : 0;
            e_vs  = (m_run && v >= VA + VFP && v < VA + VFP + VSW) ? 1 : 0;
            e_x   = (e_de == 1) ? h : 0;
            e_y   = (e_de == 1) ? v : 0;
            e_ls  = (m_run && h == 0) ? 1 : 0;
            e_fs  = (m_run && m_pos == 0) ? 1 : 0;
            m_streak = m_s2 ? m_streak + 1 : 0;
            m_pos    = (m_run && m_streak >= LS) ? (m_pos + 1) % FT : 0;
            m_run    = (m_streak >= LS);
            m_s2     = m_s1;
            m_s1     = pll_lock;
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hs", 32'(hs), 32'(e_hs));
            check("vs", 32'(vs), 32'(e_vs));
            check("de", 32'(de), 32'(e_de));
            check("x", 32'(x), 32'(e_x));
            check("y", 32'(y), 32'(e_y));
            check("line_start", 32'(line_start), 32'(e_ls));
            check("frame_start", 32'(frame_start), 32'(e_fs));
            check("running", 32'(running), 32'(e_run));
        end
    end

    // Edges from the first one sampling the new inputs until frame_start is seen.
    task automatic measure_fs(input bit use_hd, output int n);
        n = 0;
        while (n < 3000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if ((use_hd ? fs_hd : frame_start) === 1'b1) break;
        end
    endtask

    initial begin
        int n, c, c_de, c_hs, c_vs, c_fs, r;
        rst = 1'b1; pll_lock = 1'b0; pll_lock_hd = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_hs_idle", 32'(hs), 32'd0);
        check("rst_running_idle", 32'(running), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("wait_no_lock", 32'(running), 32'd0);

        pll_lock = 1'b1;
        measure_fs(1'b0, n);
        check("lock_to_frame_start", 32'(n), 32'd7);

        c_de = 0; c_hs = 0; c_vs = 0; c_fs = 0;
        for (int i = 0; i < FT; i++) begin
            c_de += int'(de);
            c_hs += int'(hs);
            c_vs += int'(vs);
            if (i > 0) c_fs += int'(frame_start);
            @(negedge clk);
        end
        check("frame_period", 32'(frame_start), 32'd1);
        check("frame_de_count", 32'(c_de), 32'(HA * VA));
        check("frame_hs_count", 32'(c_hs), 32'(HSW * VT));
        check("frame_vs_count", 32'(c_vs), 32'(VSW * HT));
        check("frame_extra_fs", 32'(c_fs), 32'd0);
        repeat (2 * FT) @(negedge clk);

        n = 0;
        while (!(de === 1'b1 && y == 12'd2 && x == 12'd5) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("glitch_point_found", 32'(n < 300), 32'd1);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        repeat (2) @(negedge clk);
        check("drop_still_running", 32'(running), 32'd1);
        @(negedge clk);
        check("drop_idle_running", 32'(running), 32'd0);
        check("drop_idle_de", 32'(de), 32'd0);
        n = 0;
        while (running !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("relock_first_fs", 32'(frame_start), 32'd1);
        check("relock_first_x", 32'(x), 32'd0);
        check("relock_first_y", 32'(y), 32'd0);

        n = 0;
        while (vs !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("vsync_found", 32'(n < 300), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_vs", 32'(vs), 32'd0);
        check("rst_mid_running", 32'(running), 32'd0);
        rst = 1'b0;
        measure_fs(1'b0, n);
        check("rst_relock_latency", 32'(n), 32'd7);

        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                pll_lock = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                pll_lock = 1'b1;
            end else if (r < 5) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end else if (r < 6) begin
                pll_lock = 1'b0;
                repeat ($urandom_range(4, 20)) @(negedge clk);
                pll_lock = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        rst = 1'b0;
        check("hd_idle_before_lock", 32'(run_hd), 32'd0);
        pll_lock_hd = 1'b1;
        measure_fs(1'b1, n);
        check("hd_lock_to_frame_start", 32'(n), 32'd1027);
        c = 0; c_de = 0; c_hs = 0;
        do begin
            c_de += int'(de_hd);
            c_hs += int'(hs_hd);
            @(negedge clk);
            c++;
        end while (ls_hd !== 1'b1 && c < 2000);
        check("hd_line_len", 32'(c), 32'd1650);
        check("hd_line_de", 32'(c_de), 32'd1280);
        check("hd_line_hs", 32'(c_hs), 32'd40);
        check("hd_line1_y", 32'(y_hd), 32'd1);
        check("hd_line1_vs", 32'(vs_hd), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
